normalize_mul_operand: RTL and testbench
========================================

NORMALIZE_MUL_OPERAND -- requirements
Module: normalize_mul_operand

Interface
REQ-001 SHALL have parameter N_BLK, default 16, meaning samples per frame (power of two, 4..64).
REQ-002 SHALL have parameter MAX_SHIFT, default 15, meaning the upper bound on the applied left shift (0..31).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port x_re_i, input, 32 bits: signed real part of the input sample.
REQ-006 SHALL have port x_im_i, input, 32 bits: signed imaginary part of the input sample.
REQ-007 SHALL have port start_i, input, 1 bit: the input sample is valid this cycle.
REQ-008 SHALL have port x_re_o, output, 32 bits: normalized real part.
REQ-009 SHALL have port x_im_o, output, 32 bits: normalized imaginary part.
REQ-010 SHALL have port start_o, output, 1 bit: the output sample is valid this cycle.
REQ-011 SHALL have port first_o, output, 1 bit: pulses with the first output sample of each frame.
REQ-012 SHALL have port exp_o, output, 5 bits: the shift applied to the current output frame; downstream uses it to undo the scaling after multiplication.

Function
REQ-013 SHALL group consecutive valid input samples (start_i=1) into frames of N_BLK; gaps with start_i=0 SHALL be allowed anywhere.
REQ-014 SHALL define the leading-sign count lsc(v) of a 32-bit value as the number of bits below the sign bit that equal the sign bit, counted contiguously from bit 30 downward (range 0..31; lsc(0)=lsc(-1)=31).
REQ-015 SHALL keep a running minimum of lsc over x_re_i and x_im_i of every sample in the frame being filled, updated on the same cycle the sample is written.
REQ-016 SHALL compute the frame exponent as min(running minimum, MAX_SHIFT), frozen when the frame's N_BLK-th sample is written.
REQ-017 SHALL use a ping-pong buffer of 2 banks x N_BLK complex words: one bank fills while the other drains.
REQ-018 SHALL have a fill FSM per bank with states EMPTY -> FILLING (first sample) -> FULL (N_BLK-th sample) -> DRAINING (next cycle) -> EMPTY (after the last output).
REQ-019 SHALL drain a FULL bank as N_BLK consecutive cycles with start_o=1, outputting each sample arithmetically left-shifted by the frozen exponent, in arrival order.
REQ-020 SHALL hold exp_o constant for the whole drain; first_o SHALL be 1 only on the drain's first cycle.
REQ-021 SHALL have a latency of 1 cycle from the frame's last input sample to the frame's first output sample.
REQ-022 SHALL not lose or overflow any sample: when fill completion of one bank and drain end of the other fall on the same cycle, the new drain starts on the next cycle and start_o may remain high continuously.
REQ-023 SHALL keep the shift lossless: no overflow or saturation is possible, because shift <= lsc.
REQ-024 SHALL drive x_re_o/x_im_o to 0 when start_o=0.

Reset
REQ-025 SHALL, while rst=1, clear both banks' FSMs to EMPTY, fill pointers to 0, running minimums to 31, and drive all outputs to 0 (exp_o=0, first_o=0, start_o=0).
REQ-026 SHALL, on reset asserted mid-frame or mid-drain, discard the partial frame; the first valid sample after release starts a new frame in bank 0.

Structure
REQ-027 SHALL place the default values of N_BLK and MAX_SHIFT and the bank-state encoding (EMPTY, FILLING, FULL, DRAINING) in the shared cwt package.
REQ-028 SHALL implement lsc as one combinational sub-module, leading_sign_count (32-bit in, 5-bit out), instantiated twice.

Verification
REQ-029 SHALL cover: 16 samples re=0x0000_0100, im=0 -> exp_o=15, re out 0x0080_0000 x16, first_o on the first output, first output one cycle after the last input.
REQ-030 SHALL cover: one sample re=0x4000_0000 within the frame, others small -> exp_o=0, all outputs equal the inputs.
REQ-031 SHALL cover: all-zero frame -> exp_o=15, outputs 0; frame of im=0xFFFF_8000, re=-1 -> exp_o=15, im out 0xC000_0000, re out 0xFFFF_8000.
REQ-032 SHALL cover: 64 back-to-back samples, no gaps -> 4 frames, start_o high for 64 consecutive cycles after 16 cycles, per-frame exp_o correct.
REQ-033 SHALL cover: random start_i gaps -> output order and frame boundaries match the reference model.
REQ-034 SHALL cover: rst pulse after 7 samples of a frame -> no output; the next 16 samples form a clean frame.

Source files
------------

// File: rtl/cwt_pkg.sv
// Shared definitions for the block-floating-point normalizer: defaults,
// widths, bank-state encoding and a small min helper.
package cwt_pkg;

    localparam int N_BLK_DEF     = 16;
    localparam int MAX_SHIFT_DEF = 15;
    localparam int DATA_W        = 32;
    localparam int EXP_W         = 5;
    localparam int NUM_LANES     = 2;   // lane 0 = real, lane 1 = imaginary

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    function automatic logic [EXP_W-1:0] min_exp(input logic [EXP_W-1:0] a,
                                                 input logic [EXP_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/leading_sign_count.sv
// Counts redundant sign bits below bit 31 (contiguous from bit 30 down);
// 0 and -1 both give 31.
module leading_sign_count
    import cwt_pkg::*;
(
    input  logic [DATA_W-1:0] v,
    output logic [EXP_W-1:0]  cnt
);

    always_comb begin
        logic run;
        cnt = '0;
        run = 1'b1;
        for (int i = DATA_W-2; i >= 0; i--) begin
            if (run && (v[i] == v[DATA_W-1])) cnt = cnt + EXP_W'(1);
            else                              run = 1'b0;
        end
    end

endmodule

// File: rtl/normalize_mul_operand.sv
// Ping-pong frame buffer that left-shifts each N_BLK-sample complex frame by
// its common headroom (capped at MAX_SHIFT) and reports the applied exponent.
module normalize_mul_operand
    import cwt_pkg::*;
#(
    parameter int N_BLK     = N_BLK_DEF,
    parameter int MAX_SHIFT = MAX_SHIFT_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_re_i,
    input  logic [DATA_W-1:0] x_im_i,
    input  logic              start_i,
    output logic [DATA_W-1:0] x_re_o,
    output logic [DATA_W-1:0] x_im_o,
    output logic              start_o,
    output logic              first_o,
    output logic [EXP_W-1:0]  exp_o
);

    localparam int                PTR_W     = $clog2(N_BLK);
    localparam logic [PTR_W-1:0]  LAST      = PTR_W'(N_BLK-1);
    localparam logic [EXP_W-1:0]  SHIFT_CAP = EXP_W'(MAX_SHIFT);

    logic [NUM_LANES-1:0][DATA_W-1:0] x_in;
    logic [NUM_LANES-1:0][EXP_W-1:0]  lsc;
    logic [NUM_LANES-1:0][DATA_W-1:0] mem_q [2][N_BLK];
    logic [NUM_LANES-1:0][DATA_W-1:0] cur;

    bank_state_t      bstate_q [2];
    bank_state_t      bstate_d [2];
    logic [EXP_W-1:0] exp_q    [2];

    logic             wr_bank, rd_bank;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [EXP_W-1:0] run_min, frame_min, shift;
    logic             wr_en, wr_last, emit, rd_last;

    assign x_in = {x_im_i, x_re_i};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        leading_sign_count u_lsc (.v(x_in[l]), .cnt(lsc[l]));
    end

    // Fill side only writes a bank that is free; drain side only reads a
    // bank that holds a complete frame, so the two never touch the same bank.
    assign wr_en     = start_i && ((bstate_q[wr_bank] == BANK_EMPTY) ||
                                   (bstate_q[wr_bank] == BANK_FILLING));
    assign wr_last   = wr_en && (wr_ptr == LAST);
    assign frame_min = min_exp(run_min, min_exp(lsc[0], lsc[1]));

    // The FULL cycle already emits sample 0, giving one cycle of latency.
    assign emit    = (bstate_q[rd_bank] == BANK_FULL) || (bstate_q[rd_bank] == BANK_DRAINING);
    assign rd_last = (bstate_q[rd_bank] == BANK_DRAINING) && (rd_ptr == LAST);

    always_comb begin
        bstate_d = bstate_q;
        if (emit)
            bstate_d[rd_bank] = rd_last ? BANK_EMPTY : BANK_DRAINING;
        if (wr_en)
            bstate_d[wr_bank] = wr_last ? BANK_FULL : BANK_FILLING;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bstate_q <= '{default: BANK_EMPTY};
        else     bstate_q <= bstate_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
            run_min <= '1;
            rd_bank <= 1'b0;
            rd_ptr  <= '0;
            exp_q   <= '{default: '0};
        end else begin
            if (wr_en) begin
                if (wr_last) begin
                    wr_ptr         <= '0;
                    wr_bank        <= ~wr_bank;
                    run_min        <= '1;
                    exp_q[wr_bank] <= min_exp(frame_min, SHIFT_CAP);
                end else begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                    run_min <= frame_min;
                end
            end
            if (emit) begin
                if (rd_last) begin
                    rd_ptr  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Sample storage carries no reset; bank state alone decides validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank][wr_ptr] <= x_in;
    end

    // shift <= lsc for every sample, so a plain left shift never overflows.
    assign cur     = mem_q[rd_bank][rd_ptr];
    assign shift   = exp_q[rd_bank];
    assign start_o = emit;
    assign first_o = emit && (bstate_q[rd_bank] == BANK_FULL);
    assign exp_o   = emit ? shift : '0;
    assign x_re_o  = emit ? (cur[0] << shift) : '0;
    assign x_im_o  = emit ? (cur[1] << shift) : '0;

endmodule

// File: tb/tb_normalize_mul_operand.sv
// Directed/table-driven bench for normalize_mul_operand with a queue-based
// reference model of frame grouping, exponent and drain timing.
module tb_normalize_mul_operand;

    localparam int N  = 16;
    localparam int MS = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_re_i, x_im_i, x_re_o, x_im_o;
    logic        start_i, start_o, first_o;
    logic [4:0]  exp_o;

    normalize_mul_operand #(.N_BLK(N), .MAX_SHIFT(MS)) dut (
        .clk(clk), .rst(rst),
        .x_re_i(x_re_i), .x_im_i(x_im_i), .start_i(start_i),
        .x_re_o(x_re_o), .x_im_o(x_im_o), .start_o(start_o),
        .first_o(first_o), .exp_o(exp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] re, im;
        logic [4:0]  e;
        logic        first;
        int          ecyc;
    } exp_t;

    typedef struct {
        logic [31:0] re, im;
        int          sp_idx;
        logic [31:0] sp_re, sp_im;
        int          e;
        logic [31:0] o0_re, o0_im;
    } vec_t;

    exp_t        expq[$];
    logic [31:0] acc_re[$], acc_im[$];
    int          tests = 0, fails = 0, cyc = 0, run = 0, maxrun = 0;
    int          force_e = -1;
    logic [31:0] force_re0, force_im0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int m_lsc(input logic [31:0] v);
        int          n = 0;
        logic [31:0] t;
        t = (v ^ {32{v[31]}}) << 1;
        while (n < 31 && t[31] == 1'b0) begin
            n++;
            t = t << 1;
        end
        return n;
    endfunction

    task automatic model_push(input logic [31:0] re, input logic [31:0] im);
        acc_re.push_back(re);
        acc_im.push_back(im);
        if (acc_re.size() == N) begin
            int   mn = 31;
            int   e;
            exp_t o;
            foreach (acc_re[i]) begin
                if (m_lsc(acc_re[i]) < mn) mn = m_lsc(acc_re[i]);
                if (m_lsc(acc_im[i]) < mn) mn = m_lsc(acc_im[i]);
            end
            e = (force_e >= 0) ? force_e : ((mn < MS) ? mn : MS);
            for (int i = 0; i < N; i++) begin
                o.re    = acc_re[i] << e;
                o.im    = acc_im[i] << e;
                o.e     = 5'(e);
                o.first = (i == 0);
                o.ecyc  = cyc;
                if (i == 0 && force_e >= 0) begin
                    o.re = force_re0;
                    o.im = force_im0;
                end
                expq.push_back(o);
            end
            acc_re.delete();
            acc_im.delete();
        end
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im);
        start_i = 1'b1;
        x_re_i  = re;
        x_im_i  = im;
        @(posedge clk); #1;
        start_i = 1'b0;
        x_re_i  = '0;
        x_im_i  = '0;
        model_push(re, im);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain_wait();
        int k = 0;
        while (expq.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", expq.size());
            expq.delete();
        end
        idle(2);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: every start_o cycle is matched against the model queue.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            run = 0;
        end else if (start_o) begin
            run++;
            if (run > maxrun) maxrun = run;
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: start_o=1 re=%h im=%h, required start_o=0", x_re_o, x_im_o);
            end else begin
                exp_t o;
                o = expq.pop_front();
                chk("re_out", x_re_o, o.re);
                chk("im_out", x_im_o, o.im);
                chk("exp_o", {27'b0, exp_o}, {27'b0, o.e});
                chk("first_o", {31'b0, first_o}, {31'b0, o.first});
                if (o.first) chk("latency_cycle", cyc, o.ecyc);
            end
        end else begin
            run = 0;
            chk("idle_zero", x_re_o | x_im_o | {31'b0, first_o}, 32'h0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        logic [31:0] r, m;

        rst = 1'b1; start_i = 1'b0; x_re_i = '0; x_im_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start_o", {31'b0, start_o}, 32'h0);
        chk("rst_first_o", {31'b0, first_o}, 32'h0);
        chk("rst_exp_o",   {27'b0, exp_o},   32'h0);
        chk("rst_re_o",    x_re_o,           32'h0);
        chk("rst_im_o",    x_im_o,           32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        //        re            im            sp  sp_re         sp_im  e   o0_re         o0_im
        vt[0] = '{32'h0000_0100, 32'h0,        -1, 32'h0,        32'h0, 15, 32'h0080_0000, 32'h0};
        vt[1] = '{32'h0000_0010, 32'h0000_0020, 5, 32'h4000_0000, 32'h0, 0,  32'h0000_0010, 32'h0000_0020};
        vt[2] = '{32'h0,         32'h0,        -1, 32'h0,        32'h0, 15, 32'h0,         32'h0};
        vt[3] = '{32'hFFFF_FFFF, 32'hFFFF_8000, -1, 32'h0,        32'h0, 15, 32'hFFFF_8000, 32'hC000_0000};
        vt[4] = '{32'h0001_0000, 32'hFFFF_FF00, -1, 32'h0,        32'h0, 14, 32'h4000_0000, 32'hFFC0_0000};
        vt[5] = '{32'h0000_0001, 32'h0000_0002, 15, 32'h8000_0000, 32'h0, 0,  32'h0000_0001, 32'h0000_0002};
        vt[6] = '{32'h0000_8000, 32'h0,        -1, 32'h0,        32'h0, 15, 32'h4000_0000, 32'h0};

        foreach (vt[v]) begin
            force_e   = vt[v].e;
            force_re0 = vt[v].o0_re;
            force_im0 = vt[v].o0_im;
            for (int i = 0; i < N; i++) begin
                if (i == vt[v].sp_idx) send(vt[v].sp_re, vt[v].sp_im);
                else                   send(vt[v].re, vt[v].im);
                if (v % 2 == 1 && i % 5 == 2) idle(1);
            end
            drain_wait();
        end
        force_e = -1;

        // 64 back-to-back samples, a different headroom per frame.
        maxrun = 0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < N; i++)
                send(32'(i + 1) << (4 * f + 6), ~32'(i));
        drain_wait();
        chk("b2b_start_run", maxrun, 32'd64);

        // Random values and random gaps.
        for (int k = 0; k < 3 * N; k++) begin
            r = $urandom;
            m = $urandom;
            r = $signed(r) >>> $urandom_range(1, 31);
            m = $signed(m) >>> $urandom_range(1, 31);
            send(r, m);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
        end
        drain_wait();

        // Reset after 7 samples of a frame: nothing may come out.
        for (int i = 0; i < 7; i++) send(32'h0000_4000 + 32'(i), 32'h1);
        rst = 1'b1;
        acc_re.delete(); acc_im.delete();
        idle(2);
        rst = 1'b0;
        idle(25);
        for (int i = 0; i < N; i++) send(32'h0000_0300 - 32'(i), 32'hFFFF_F000 + 32'(i));
        drain_wait();

        // Reset in the middle of a drain, then a clean frame.
        for (int i = 0; i < N; i++) send(32'(i) << 20, 32'h0);
        idle(4);
        rst = 1'b1;
        expq.delete();
        idle(2);
        rst = 1'b0;
        idle(20);
        for (int i = 0; i < N; i++) send(32'h7 * 32'(i), -32'(i));
        drain_wait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
